// File: rtl/leaf_message_responder_if.sv
// Parent-link bundle for the leaf endpoint.
//   down_rx_*  : 64-bit messages from the root hub (valid/ready)
//   up_tx_*    : 64-bit reports to the root hub (valid/ready)
// master = parent side (drives down words, accepts reports)
// slave  = leaf_message_responder
interface leaf_message_responder_if;
    logic [63:0] down_rx_data;
    logic        down_rx_valid;
    logic        down_rx_ready;
    logic [63:0] up_tx_data;
    logic        up_tx_valid;
    logic        up_tx_ready;

    modport master (
        output down_rx_data, down_rx_valid, up_tx_ready,
        input  down_rx_ready, up_tx_data, up_tx_valid
    );

    modport slave (
        input  down_rx_data, down_rx_valid, up_tx_ready,
        output down_rx_ready, up_tx_data, up_tx_valid
    );
endinterface

// File: rtl/leaf_message_responder.sv
// Leaf-side endpoint of the root-hub channel protocol.
// Consumes CONFIG / SYNDROME / START words addressed to this leaf, drives the
// local decoder, times each decode and returns one latency report per test.
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   link (slave)    : parent link, down_rx_* in, up_tx_* out
//   cfg_data/valid  : registered CONFIG payload, one-cycle pulse
//   syndrome_*      : syndrome words passed straight through to the decoder
//   decode_start    : registered one-cycle pulse starting a decode
//   decode_done     : decoder finished (level or pulse)
//   busy            : FSM not in IDLE
module leaf_message_responder #(
    parameter logic [7:0]  FPGA_ID        = 8'd1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFF0
) (
    input  logic                      clk,
    input  logic                      reset,
    leaf_message_responder_if.slave   link,
    output logic [47:0]               cfg_data,
    output logic                      cfg_valid,
    output logic [47:0]               syndrome_data,
    output logic                      syndrome_valid,
    input  logic                      syndrome_ready,
    output logic                      decode_start,
    input  logic                      decode_done,
    output logic                      busy
);
    localparam logic [7:0] T_CONFIG   = 8'h01;
    localparam logic [7:0] T_SYNDROME = 8'h02;
    localparam logic [7:0] T_START    = 8'h03;
    localparam logic [7:0] R_NORMAL   = 8'h10;
    localparam logic [7:0] R_TIMEOUT  = 8'h11;

    typedef enum logic [1:0] {IDLE, DECODE, REPORT} state_t;

    state_t      state, state_nxt;
    logic [15:0] cycle_cnt;
    logic [15:0] test_id;

    logic [7:0]  msg_dest, msg_type;
    logic        addressed, is_syn, accept;
    logic        cfg_accept, start_accept;
    logic        dec_active, done_hit, tmo_hit, tx_fire;

    assign msg_dest      = link.down_rx_data[63:56];
    assign msg_type      = link.down_rx_data[55:48];
    assign addressed     = (msg_dest == FPGA_ID) || (msg_dest == 8'hFF);
    assign is_syn        = addressed && (msg_type == T_SYNDROME);
    assign syndrome_data = link.down_rx_data[47:0];
    assign busy          = (state != IDLE);

    assign accept       = link.down_rx_valid && link.down_rx_ready;
    assign cfg_accept   = accept && addressed && (msg_type == T_CONFIG);
    assign start_accept = accept && addressed && (msg_type == T_START);

    // The decode_start cycle is excluded so a stale done from the previous
    // test cannot end a fresh decode. cycle_cnt holds 0 through that cycle,
    // so cycle_cnt+1 equals the number of cycles since decode_start.
    assign dec_active = (state == DECODE) && !decode_start;
    assign done_hit   = dec_active && decode_done;
    assign tmo_hit    = dec_active && !decode_done &&
                        ((cycle_cnt + 16'd1) == TIMEOUT_CYCLES);
    assign tx_fire    = link.up_tx_valid && link.up_tx_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the combinational down-link handshake. Only registered
    // state feeds these outputs besides down_rx_data/valid and syndrome_ready.
    always_comb begin
        state_nxt          = state;
        link.down_rx_ready = 1'b0;
        syndrome_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    // Syndromes flow through unbuffered; everything else
                    // (including dropped words) is consumed immediately.
                    link.down_rx_ready = is_syn ? syndrome_ready : 1'b1;
                    syndrome_valid     = link.down_rx_valid && is_syn;
                end
                if (start_accept) state_nxt = DECODE;
            end
            DECODE: if (done_hit || tmo_hit) state_nxt = REPORT;
            REPORT: if (tx_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt        <= '0;
            test_id          <= '0;
            cfg_valid        <= 1'b0;
            cfg_data         <= '0;
            decode_start     <= 1'b0;
            link.up_tx_valid <= 1'b0;
            link.up_tx_data  <= '0;
        end else begin
            cfg_valid    <= cfg_accept;
            decode_start <= start_accept;
            if (cfg_accept) cfg_data <= link.down_rx_data[47:0];

            // Saturating guard: the count must never wrap back to 0.
            if (start_accept)
                cycle_cnt <= '0;
            else if (dec_active && cycle_cnt != 16'hFFFF)
                cycle_cnt <= cycle_cnt + 16'd1;

            // Done is checked first so it wins over a same-cycle timeout.
            if (done_hit) begin
                link.up_tx_valid <= 1'b1;
                link.up_tx_data  <= {8'h00, R_NORMAL, FPGA_ID, 8'h00,
                                     test_id, cycle_cnt + 16'd1};
            end else if (tmo_hit) begin
                link.up_tx_valid <= 1'b1;
                link.up_tx_data  <= {8'h00, R_TIMEOUT, FPGA_ID, 8'h00,
                                     test_id, 16'hFFFF};
            end else if (tx_fire) begin
                link.up_tx_valid <= 1'b0;
                test_id          <= test_id + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_leaf_message_responder.sv
module tb_leaf_message_responder;
    localparam logic [7:0]  ID  = 8'd1;
    localparam int          TMO = 20;
    localparam logic [63:0] START_W = 64'h0103_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] cfg_data, syndrome_data;
    logic        cfg_valid, syndrome_valid, syndrome_ready;
    logic        decode_start, decode_done, busy;

    leaf_message_responder_if bus();

    leaf_message_responder #(.FPGA_ID(ID), .TIMEOUT_CYCLES(16'(TMO))) dut (
        .clk(clk), .reset(reset), .link(bus),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .syndrome_data(syndrome_data), .syndrome_valid(syndrome_valid),
        .syndrome_ready(syndrome_ready),
        .decode_start(decode_start), .decode_done(decode_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m_tid = '0;     // reference model: expected test_id
    logic [47:0] syn_q[$];       // syndrome words the decoder actually took

    always @(posedge clk)
        if (!reset && syndrome_valid && syndrome_ready) syn_q.push_back(syndrome_data);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One full test: START, decoder reports done k cycles after decode_start
    // (k > TMO never finishes), report stalled for 'stall' cycles, then either
    // handshaken or killed by reset. Expected report comes from the rule set:
    // done at k <= TMO -> type 10 latency k; otherwise type 11 latency FFFF
    // decided TMO cycles after decode_start.
    task automatic run_decode(input int k, input int stall, input bit early_done, input bit abort);
        logic [63:0] exp;
        int j_end;
        j_end = (k < TMO) ? k : TMO;
        exp = (k <= TMO) ? {8'h00, 8'h10, ID, 8'h00, m_tid, 16'(k)}
                         : {8'h00, 8'h11, ID, 8'h00, m_tid, 16'hFFFF};
        bus.down_rx_data  = START_W;
        bus.down_rx_valid = 1'b1;
        #1 chk("start_ready", 64'(bus.down_rx_ready), 64'd1);
        tick();
        chk("decode_start_pulse", 64'(decode_start), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        decode_done = early_done;           // must be ignored
        #1 chk("decode_backpressure", 64'(bus.down_rx_ready), 64'd0);
        tick();
        for (int j = 1; j <= j_end; j++) begin
            decode_done = (j == k);
            if (j == 1) chk("decode_start_one_cycle", 64'(decode_start), 64'd0);
            if (j == j_end) chk("no_report_early", 64'(bus.up_tx_valid), 64'd0);
            #1 chk("decode_rx_ready", 64'(bus.down_rx_ready), 64'd0);
            chk("decode_no_syn", 64'(syndrome_valid), 64'd0);
            tick();
        end
        decode_done = 1'b0;
        chk("report_valid", 64'(bus.up_tx_valid), 64'd1);
        chk("report_data", bus.up_tx_data, exp);
        for (int s = 0; s < stall; s++) begin
            bus.up_tx_ready = 1'b0;
            decode_done = 1'($urandom_range(0, 1));   // ignored in REPORT
            #1 chk("stall_rx_ready", 64'(bus.down_rx_ready), 64'd0);
            tick();
            chk("stall_valid", 64'(bus.up_tx_valid), 64'd1);
            chk("stall_data", bus.up_tx_data, exp);
        end
        decode_done = 1'b0;
        if (abort) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            bus.down_rx_valid = 1'b0;
            chk("abort_valid", 64'(bus.up_tx_valid), 64'd0);
            chk("abort_data", bus.up_tx_data, 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            m_tid = '0;
        end else begin
            bus.up_tx_ready = 1'b1;
            #1 chk("hs_rx_ready", 64'(bus.down_rx_ready), 64'd0);
            tick();
            bus.up_tx_ready = 1'b0;
            m_tid++;
            chk("post_hs_valid", 64'(bus.up_tx_valid), 64'd0);
            chk("post_hs_idle", 64'(busy), 64'd0);
            // START still offered: the next call's first cycle is back-to-back.
        end
    endtask

    typedef struct {
        logic [63:0] word;
        logic        vld;
        logic        srdy;
        logic        exp_rdy;
        logic        exp_sv;
        logic        exp_cfg;
    } vec_t;

    vec_t tbl[11];

    initial begin
        reset = 1'b1;
        bus.down_rx_data = START_W; bus.down_rx_valid = 1'b1; bus.up_tx_ready = 1'b0;
        syndrome_ready = 1'b1; decode_done = 1'b0;
        tick(); tick();
        chk("rst_rx_ready", 64'(bus.down_rx_ready), 64'd0);
        chk("rst_syn_valid", 64'(syndrome_valid), 64'd0);
        chk("rst_tx_valid", 64'(bus.up_tx_valid), 64'd0);
        chk("rst_tx_data", bus.up_tx_data, 64'd0);
        chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("rst_dstart_busy", {62'd0, decode_start, busy}, 64'd0);
        bus.down_rx_valid = 1'b0;
        reset = 1'b0;
        tick();

        //        word                    vld srdy rdy sv cfg
        tbl[0]  = '{64'h0101_0000_0000_ABCD, 1, 0, 1, 0, 1};
        tbl[1]  = '{64'h0201_0000_0000_1111, 1, 1, 1, 0, 0};  // other leaf
        tbl[2]  = '{64'hFF01_0000_1234_5678, 1, 0, 1, 0, 1};  // broadcast
        tbl[3]  = '{64'h0107_0000_0000_2222, 1, 0, 1, 0, 0};  // unknown type
        tbl[4]  = '{64'h0102_0000_0000_0001, 1, 1, 1, 1, 0};
        tbl[5]  = '{64'h0102_0000_0000_0002, 1, 0, 0, 1, 0};
        tbl[6]  = '{64'h0102_0000_0000_0002, 1, 1, 1, 1, 0};
        tbl[7]  = '{64'hFF02_0000_0000_0003, 1, 0, 0, 1, 0};
        tbl[8]  = '{64'hFF02_0000_0000_0003, 1, 1, 1, 1, 0};
        tbl[9]  = '{64'h0302_0000_0000_0009, 1, 1, 1, 0, 0};  // other leaf
        tbl[10] = '{64'h0101_0000_0000_7777, 0, 0, 1, 0, 0};  // not valid
        for (int i = 0; i < 11; i++) begin
            bus.down_rx_data  = tbl[i].word;
            bus.down_rx_valid = tbl[i].vld;
            syndrome_ready    = tbl[i].srdy;
            #1 chk($sformatf("vec%0d_rx_ready", i), 64'(bus.down_rx_ready), 64'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_syn_valid", i), 64'(syndrome_valid), 64'(tbl[i].exp_sv));
            if (tbl[i].exp_sv)
                chk($sformatf("vec%0d_syn_data", i), 64'(syndrome_data), 64'(tbl[i].word[47:0]));
            tick();
            chk($sformatf("vec%0d_cfg_valid", i), 64'(cfg_valid), 64'(tbl[i].exp_cfg));
            if (tbl[i].exp_cfg)
                chk($sformatf("vec%0d_cfg_data", i), 64'(cfg_data), 64'(tbl[i].word[47:0]));
        end
        bus.down_rx_valid = 1'b0;
        syndrome_ready = 1'b1;
        tick();
        chk("cfg_pulse_end", 64'(cfg_valid), 64'd0);
        chk("syn_count", 64'(syn_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < syn_q.size(); i++)
            chk($sformatf("syn_order%0d", i), 64'(syn_q[i]), 64'(i + 1));

        // Directed decodes: k=7 (tid 0), second test with stall and back-to-back
        // START, timeout, done/timeout tie, reset mid-report then k=4.
        run_decode(7, 0, 1'b1, 1'b0);
        run_decode(5, 5, 1'b0, 1'b0);
        run_decode(30, 1, 1'b0, 1'b0);
        run_decode(TMO, 0, 1'b0, 1'b0);
        run_decode(TMO - 1, 0, 1'b0, 1'b0);
        run_decode(3, 2, 1'b0, 1'b1);
        run_decode(4, 0, 1'b0, 1'b0);
        bus.down_rx_valid = 1'b0;
        tick();

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0]  d;
                logic [47:0] p;
                logic        hit;
                case ($urandom_range(0, 2))
                    0: d = 8'h01;
                    1: d = 8'hFF;
                    default: d = 8'h05;
                endcase
                p = {16'($urandom), 32'($urandom)};
                hit = (d == ID) || (d == 8'hFF);
                bus.down_rx_data = {d, 8'h01, p};
                bus.down_rx_valid = 1'b1;
                tick();
                bus.down_rx_valid = 1'b0;
                chk("rnd_cfg_valid", 64'(cfg_valid), 64'(hit));
                if (hit) chk("rnd_cfg_data", 64'(cfg_data), 64'(p));
            end
            run_decode(int'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
            bus.down_rx_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/leaf_message_responder.md
# leaf_message_responder

Leaf-side endpoint of the root-hub channel protocol. It sits on a leaf FPGA behind that FPGA's 64-bit parent link. It consumes configuration, syndrome and start messages sent down by the root hub and hands them to the local decoder. It times each decode and sends one 64-bit latency report back up per test case; the root reads the latency from bits [15:0].

## Interface
Parameters:
- FPGA_ID, 1, this leaf's 8-bit destination ID.
- TIMEOUT_CYCLES, 16'hFFF0, decode cycle count at which the decode is abandoned and a timeout report is sent.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- down_rx_data  in  64  message from parent.
- down_rx_valid  in  1  word available.
- down_rx_ready  out  1  word consumed this cycle when valid & ready.
- up_tx_data  out  64  report to parent; registered.
- up_tx_valid  out  1  report pending; registered.
- up_tx_ready  in  1  parent accepts.
- cfg_data  out  48  configuration payload; registered.
- cfg_valid  out  1  one-cycle pulse per accepted CONFIG.
- syndrome_data  out  48  syndrome payload; combinational from down_rx_data[47:0].
- syndrome_valid  out  1  syndrome word offered to decoder.
- syndrome_ready  in  1  decoder accepts syndrome word.
- decode_start  out  1  one-cycle pulse; registered.
- decode_done  in  1  decoder finished; level or pulse.
- busy  out  1  state != IDLE.

## Operation
Down message format:
- [63:56] is the destination. A word is addressed to this leaf when dest == FPGA_ID or dest == 8'hFF.
- [55:48] is the type: 8'h01 CONFIG, 8'h02 SYNDROME, 8'h03 START.
- [47:0] is the payload.

Up report format:
- [63:56] = 8'h00.
- [55:48] = 8'h10 for a normal report, 8'h11 for a timeout report.
- [47:40] = FPGA_ID.
- [39:32] = 0.
- [31:16] = test_id.
- [15:0] = latency.

FSM states: IDLE, DECODE, REPORT.

IDLE:
- Non-addressed words and unknown types: down_rx_ready=1, the word is dropped.
- CONFIG: down_rx_ready=1; next cycle cfg_data=payload and cfg_valid=1 for exactly one cycle.
- SYNDROME: syndrome_valid=down_rx_valid and down_rx_ready=syndrome_ready. Words are forwarded in arrival order with no buffering.
- START: down_rx_ready=1; next cycle decode_start=1, cycle_cnt=0, state→DECODE.

DECODE:
- down_rx_ready=0 and syndrome_valid=0; the parent is back-pressured.
- cycle_cnt increments by 1 each cycle. It is 16 bits and never wraps.
- If decode_done=1 in the decode_start cycle it is ignored.
- decode_done=1 in any later cycle: latch latency=cycle_cnt+1, type 8'h10, state→REPORT.
- cycle_cnt+1 == TIMEOUT_CYCLES without done: latency=16'hFFFF, type 8'h11, state→REPORT.
- When done and timeout fall in the same cycle, done wins.

REPORT:
- up_tx_valid=1; up_tx_data is held stable until up_tx_ready=1.
- On the handshake cycle: test_id increments by 1 (16-bit, wraps FFFF→0000), and up_tx_valid=0 and state=IDLE from the next cycle.
- down_rx_ready=0 throughout.
- decode_done in REPORT or IDLE is ignored.

Reset (any state, including mid-report) forces:
- state=IDLE, test_id=0, cycle_cnt=0.
- up_tx_valid=0, up_tx_data=0, cfg_valid=0, cfg_data=0, decode_start=0, busy=0.
- While reset=1: down_rx_ready=0 and syndrome_valid=0.
- A pending report is discarded, not sent.

## Timing
- down_rx_ready and syndrome_valid are combinational from state, down_rx_data and syndrome_ready. No combinational path exists from up_tx_ready to any output.
- START accepted at cycle T: decode_start=1 at T+1, busy=1 at T+1.
- decode_done sampled at T+1+k (k≥1): latency=k, up_tx_valid=1 at T+2+k.
- Minimum START-to-report latency: 3 cycles.
- Back-to-back: a START arriving the cycle after the report handshake is accepted (IDLE is occupied for 1 cycle minimum).
- Throughput in IDLE: one down word per cycle, limited for SYNDROME words only by syndrome_ready.

## Test plan
- Reset, then CONFIG 64'h0101_0000_0000_ABCD → cfg_valid one cycle, cfg_data=48'h0000_0000_ABCD. A CONFIG with dest 8'h02 → dropped, no cfg_valid.
- Three SYNDROME words, payloads 1, 2, 3, with syndrome_ready toggling 1/0 → decoder receives 1, 2, 3 in order, each exactly once, and down_rx_ready mirrors syndrome_ready.
- START, done asserted 7 cycles after decode_start → up_tx_data=64'h0010_0100_0000_0007. A second test → test_id field = 1.
- Report pending, up_tx_ready held 0 for 5 cycles → data stable, valid stays 1, down_rx_ready=0. A START presented meanwhile is accepted only after the handshake.
- TIMEOUT_CYCLES=16'd20, done never asserted → report type 8'h11, latency 16'hFFFF, sent 20 cycles after decode_start.
- Reset asserted during REPORT → up_tx_valid=0 the next cycle, test_id=0. Next START/done(k=4) → report test_id=0, latency=4.
